key_press_pulser: RTL

//  Front end for the player keys: turns raw, bouncing, active-low DE1-SoC KEY

---
 rtl/key_press_pulser.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/key_press_pulser.sv
// Player-key front end: two independent channels turn raw active-low keys into
// debounced single-cycle move pulses, with optional hold-to-repeat.

module key_press_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
    localparam logic          REPEAT_EN = (REPEAT_CYCLES > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic          w_pressed;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [RW-1:0] r_rpt;
    logic [RW-1:0] w_rpt_nxt;
    logic          r_pulse;
    logic          w_pulse_nxt;

    // Two-flop synchroniser; resets to the released level so a key held
    // through reset is seen as a fresh press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;

    // State, counters and the registered pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rpt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rpt   <= w_rpt_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    // Next-state logic; counters restart on every state change so they never wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rpt_nxt   = r_rpt;
        w_pulse_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pressed) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_rpt_nxt   = '0;
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_HELD: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                    w_rpt_nxt   = '0;
                end else if (REPEAT_EN && (r_rpt == RPT_LAST)) begin
                    w_rpt_nxt   = '0;
                    w_pulse_nxt = 1'b1;
                end else if (REPEAT_EN) begin
                    w_rpt_nxt = r_rpt + RW'(1);
                end else begin
                    w_rpt_nxt = r_rpt;
                end
            end
            ST_RELEASE_WAIT: begin
                // A press seen here is release bounce: back to HELD without a pulse.
                if (w_pressed) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_rpt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_rpt_nxt   = '0;
            end
        endcase
    end

    assign o_pulse = r_pulse;

endmodule

module key_press_pulser #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_l,
    input  logic i_key_r,
    output logic o_l,
    output logic o_r
);

    key_press_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_left (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_key  (i_key_l),
        .o_pulse(o_l)
    );

    key_press_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_right (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_key  (i_key_r),
        .o_pulse(o_r)
    );

endmodule
